universal_shift_register_n: RTL and testbench



---
 rtl/shift_reg_pkg.sv | 19 +
 rtl/usr_bit_slice.sv | 50 +++++
 rtl/universal_shift_register_n.sv | 100 ++++++++++
 tb/tb_universal_shift_register_n.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the bits_left counter width helper.
package shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_LOAD  = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_ROL   = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;
    localparam logic [2:0] MODE_RSVD  = 3'b111;

    // Counter must hold values 0..width inclusive.
    function automatic int calc_cw(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/usr_bit_slice.sv
// One bit of the universal shift register: mode-selected next-value mux
// feeding an enabled flop with asynchronous reset.
module usr_bit_slice
    import shift_reg_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [2:0] mode,
    input  logic       par_bit,
    input  logic       shr_bit,
    input  logic       shl_bit,
    input  logic       ror_bit,
    input  logic       rol_bit,
    output logic       q
);

    logic bit_d;
    logic bit_q;

    // End slices get the serial inputs on shifts and the wrapped bit on rotates;
    // interior slices see the same neighbour on both.
    always_comb begin
        bit_d = bit_q;
        case (mode)
            MODE_HOLD,
            MODE_RSVD:  bit_d = bit_q;
            MODE_SHR:   bit_d = shr_bit;
            MODE_SHL:   bit_d = shl_bit;
            MODE_LOAD:  bit_d = par_bit;
            MODE_ROR:   bit_d = ror_bit;
            MODE_ROL:   bit_d = rol_bit;
            MODE_CLEAR: bit_d = RESET_BIT;
            default:    bit_d = bit_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_q <= RESET_BIT;
        end else if (en) begin
            bit_q <= bit_d;
        end
    end

    assign q = bit_q;

endmodule

// File: rtl/universal_shift_register_n.sv
// N-bit universal shift register with serial in/out on both ends and a
// count of loaded bits not yet shifted out (serialiser/deserialiser front end).
module universal_shift_register_n
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              CW          = calc_cw(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] par_in,
    input  logic             ser_in_msb,
    input  logic             ser_in_lsb,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_lsb,
    output logic             ser_out_msb,
    output logic [CW-1:0]    bits_left,
    output logic             empty
);

    logic [WIDTH-1:0] q_q;
    logic [CW-1:0]    bits_left_d;
    logic [CW-1:0]    bits_left_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic hi_shift;
        logic hi_rot;
        logic lo_shift;
        logic lo_rot;

        if (i == WIDTH - 1) begin : g_top
            assign hi_shift = ser_in_msb;
            assign hi_rot   = q_q[0];
        end else begin : g_hi
            assign hi_shift = q_q[i+1];
            assign hi_rot   = q_q[i+1];
        end

        if (i == 0) begin : g_bot
            assign lo_shift = ser_in_lsb;
            assign lo_rot   = q_q[WIDTH-1];
        end else begin : g_lo
            assign lo_shift = q_q[i-1];
            assign lo_rot   = q_q[i-1];
        end

        usr_bit_slice #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_slice (
            .clk     (clk),
            .reset   (reset),
            .en      (en),
            .mode    (mode),
            .par_bit (par_in[i]),
            .shr_bit (hi_shift),
            .shl_bit (lo_shift),
            .ror_bit (hi_rot),
            .rol_bit (lo_rot),
            .q       (q_q[i])
        );
    end

    // Shifts consume one loaded bit, saturating at zero; rotates keep the count.
    always_comb begin
        bits_left_d = bits_left_q;
        case (mode)
            MODE_SHR,
            MODE_SHL: begin
                if (bits_left_q != '0) begin
                    bits_left_d = bits_left_q - CW'(1);
                end
            end
            MODE_LOAD:  bits_left_d = CW'(WIDTH);
            MODE_CLEAR: bits_left_d = '0;
            MODE_HOLD,
            MODE_ROR,
            MODE_ROL,
            MODE_RSVD:  bits_left_d = bits_left_q;
            default:    bits_left_d = bits_left_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bits_left_q <= '0;
        end else if (en) begin
            bits_left_q <= bits_left_d;
        end
    end

    assign q           = q_q;
    assign ser_out_lsb = q_q[0];
    assign ser_out_msb = q_q[WIDTH-1];
    assign bits_left   = bits_left_q;
    assign empty       = (bits_left_q == '0);

endmodule

// File: tb/tb_universal_shift_register_n.sv
// Self-checking bench for universal_shift_register_n: directed scenarios plus
// randomized operation against an arithmetic reference model, at WIDTH 8, 2 and 33.
module tb_universal_shift_register_n;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [2:0]  mode = 3'b000;
    logic        ser_in_msb = 1'b0;
    logic        ser_in_lsb = 1'b0;
    logic [7:0]  par8 = '0;
    logic [1:0]  par2 = '0;
    logic [32:0] par33 = '0;

    logic [7:0]  q8;
    logic        sol8, som8, e8;
    logic [3:0]  bl8;
    logic [1:0]  q2;
    logic        sol2, som2, e2;
    logic [1:0]  bl2;
    logic [32:0] q33;
    logic        sol33, som33, e33;
    logic [5:0]  bl33;

    int total = 0;
    int bad = 0;
    int rsvd_seen = 0;
    logic [7:0] m_q = '0;
    int         m_bl = 0;

    universal_shift_register_n #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .par_in(par8),
        .ser_in_msb(ser_in_msb), .ser_in_lsb(ser_in_lsb), .q(q8),
        .ser_out_lsb(sol8), .ser_out_msb(som8), .bits_left(bl8), .empty(e8));

    universal_shift_register_n #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .par_in(par2),
        .ser_in_msb(ser_in_msb), .ser_in_lsb(ser_in_lsb), .q(q2),
        .ser_out_lsb(sol2), .ser_out_msb(som2), .bits_left(bl2), .empty(e2));

    universal_shift_register_n #(.WIDTH(33)) dut33 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .par_in(par33),
        .ser_in_msb(ser_in_msb), .ser_in_lsb(ser_in_lsb), .q(q33),
        .ser_out_lsb(sol33), .ser_out_msb(som33), .bits_left(bl33), .empty(e33));

    always #5 clk = ~clk;

    // Drive one operation, take the edge, sample 1ns later, advance the model.
    task automatic step(input logic e, input logic [2:0] md, input logic [7:0] p,
                        input logic smsb, input logic slsb);
        en = e; mode = md; par8 = p; ser_in_msb = smsb; ser_in_lsb = slsb;
        @(posedge clk);
        #1;
        if (e) begin
            case (md)
                3'd1: begin
                    m_q = (m_q >> 1) + (smsb ? 8'h80 : 8'h00);
                    m_bl = (m_bl > 0) ? m_bl - 1 : 0;
                end
                3'd2: begin
                    m_q = 8'((m_q * 2) + (slsb ? 1 : 0));
                    m_bl = (m_bl > 0) ? m_bl - 1 : 0;
                end
                3'd3: begin m_q = p; m_bl = 8; end
                3'd4: m_q = (m_q >> 1) + ((m_q % 2 == 1) ? 8'h80 : 8'h00);
                3'd5: m_q = 8'((m_q * 2) + ((m_q >= 8'h80) ? 1 : 0));
                3'd6: begin m_q = 8'h00; m_bl = 0; end
                3'd7: rsvd_seen++;
                default: ;
            endcase
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        m_q = '0; m_bl = 0;
        total++; if (q8 !== 8'h00) begin bad++; $display("FAIL reset_q got=%h exp=00", q8); end
        total++; if (bl8 !== 4'd0) begin bad++; $display("FAIL reset_bl got=%0d exp=0", bl8); end
        total++; if (e8 !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", e8); end
        step(1'b1, 3'd3, 8'hA5, 1'b0, 1'b0);
        total++; if (q8 !== 8'hA5) begin bad++; $display("FAIL load_a5 got=%h exp=a5", q8); end
        #3 reset = 1'b1;
        #1;
        m_q = '0; m_bl = 0;
        total++; if (q8 !== 8'h00) begin bad++; $display("FAIL async_reset_q got=%h exp=00", q8); end
        total++; if (bl8 !== 4'd0) begin bad++; $display("FAIL async_reset_bl got=%0d exp=0", bl8); end
        total++; if (e8 !== 1'b1) begin bad++; $display("FAIL async_reset_empty got=%b exp=1", e8); end
        #1 reset = 1'b0;
        step(1'b1, 3'd3, 8'h3C, 1'b0, 1'b0);
        total++; if (q8 !== 8'h3C) begin bad++; $display("FAIL first_edge_after_reset got=%h exp=3c", q8); end
    endtask

    task automatic test_shr;
        logic [7:0] exp_seq;
        exp_seq = 8'hB4;
        step(1'b1, 3'd3, 8'hB4, 1'b0, 1'b0);
        total++; if (q8 !== 8'hB4) begin bad++; $display("FAIL shr_load got=%h exp=b4", q8); end
        total++; if (bl8 !== 4'd8) begin bad++; $display("FAIL shr_load_bl got=%0d exp=8", bl8); end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (sol8 !== exp_seq[k]) begin
                bad++; $display("FAIL shr_ser_out_lsb[%0d] got=%b exp=%b", k, sol8, exp_seq[k]);
            end
            step(1'b1, 3'd1, 8'h00, 1'b0, 1'b0);
            total++;
            if (bl8 !== 4'(7 - k)) begin bad++; $display("FAIL shr_bl[%0d] got=%0d exp=%0d", k, bl8, 7 - k); end
        end
        total++; if (q8 !== 8'h00) begin bad++; $display("FAIL shr_final_q got=%h exp=00", q8); end
        total++; if (e8 !== 1'b1) begin bad++; $display("FAIL shr_final_empty got=%b exp=1", e8); end
        step(1'b1, 3'd1, 8'h00, 1'b1, 1'b0);
        total++; if (bl8 !== 4'd0) begin bad++; $display("FAIL shr_saturate_bl got=%0d exp=0", bl8); end
        total++; if (q8 !== 8'h80) begin bad++; $display("FAIL shr_past_empty_q got=%h exp=80", q8); end
    endtask

    task automatic test_shl;
        step(1'b1, 3'd3, 8'h81, 1'b0, 1'b0);
        total++; if (som8 !== 1'b1) begin bad++; $display("FAIL shl_msb_before got=%b exp=1", som8); end
        step(1'b1, 3'd2, 8'h00, 1'b0, 1'b1);
        total++; if (q8 !== 8'h03) begin bad++; $display("FAIL shl_q got=%h exp=03", q8); end
        total++; if (som8 !== 1'b0) begin bad++; $display("FAIL shl_ser_out_msb got=%b exp=0", som8); end
        total++; if (bl8 !== 4'd7) begin bad++; $display("FAIL shl_bl got=%0d exp=7", bl8); end
    endtask

    task automatic test_ror;
        logic [7:0] exp_q;
        step(1'b1, 3'd3, 8'h01, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
            exp_q = 8'(16'h0100 >> k) | 8'(16'h0001 >> k);
            if (k == 8) exp_q = 8'h01;
            total++; if (q8 !== exp_q) begin bad++; $display("FAIL ror_q[%0d] got=%h exp=%h", k, q8, exp_q); end
            total++; if (bl8 !== 4'd8) begin bad++; $display("FAIL ror_bl[%0d] got=%0d exp=8", k, bl8); end
        end
    endtask

    task automatic test_en_hold;
        logic [7:0] q_before;
        logic [3:0] bl_before;
        step(1'b1, 3'd3, 8'h5A, 1'b0, 1'b0);
        step(1'b1, 3'd1, 8'h00, 1'b1, 1'b0);
        q_before = m_q; bl_before = 4'(m_bl);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 3'd3, 8'hFF, 1'b1, 1'b1);
            total++; if (q8 !== q_before) begin bad++; $display("FAIL en_low_q[%0d] got=%h exp=%h", k, q8, q_before); end
            total++; if (bl8 !== bl_before) begin bad++; $display("FAIL en_low_bl[%0d] got=%0d exp=%0d", k, bl8, bl_before); end
        end
        step(1'b1, 3'd7, 8'hFF, 1'b1, 1'b1);
        total++; if (q8 !== q_before) begin bad++; $display("FAIL rsvd_q got=%h exp=%h", q8, q_before); end
        total++; if (bl8 !== bl_before) begin bad++; $display("FAIL rsvd_bl got=%0d exp=%0d", bl8, bl_before); end
        step(1'b1, 3'd6, 8'hFF, 1'b1, 1'b1);
        total++; if (q8 !== 8'h00) begin bad++; $display("FAIL clear_q got=%h exp=00", q8); end
        total++; if (bl8 !== 4'd0) begin bad++; $display("FAIL clear_bl got=%0d exp=0", bl8); end
    endtask

    task automatic test_random;
        logic       e;
        logic [2:0] md;
        for (int k = 0; k < 400; k++) begin
            e  = ($urandom_range(0, 7) != 0);
            md = 3'($urandom_range(0, 7));
            step(e, md, 8'($urandom), 1'($urandom), 1'($urandom));
            total++; if (q8 !== m_q) begin bad++; $display("FAIL rand_q[%0d] got=%h exp=%h", k, q8, m_q); end
            total++; if (bl8 !== 4'(m_bl)) begin bad++; $display("FAIL rand_bl[%0d] got=%0d exp=%0d", k, bl8, m_bl); end
            total++; if (e8 !== (m_bl == 0)) begin bad++; $display("FAIL rand_empty[%0d] got=%b exp=%b", k, e8, m_bl == 0); end
            total++; if (sol8 !== m_q[0]) begin bad++; $display("FAIL rand_sol[%0d] got=%b exp=%b", k, sol8, m_q[0]); end
            total++; if (som8 !== m_q[7]) begin bad++; $display("FAIL rand_som[%0d] got=%b exp=%b", k, som8, m_q[7]); end
            total++; if (m_bl > 8) begin bad++; $display("FAIL rand_bl_bound[%0d] got=%0d exp<=8", k, m_bl); end
        end
    endtask

    task automatic test_sweep;
        logic [32:0] v33, exp33;
        logic [1:0]  exp2;
        v33 = 33'h1_5555_5555;
        par33 = v33;
        par2 = 2'b10;
        step(1'b1, 3'd3, 8'h00, 1'b0, 1'b0);
        total++; if (bl33 !== 6'd33) begin bad++; $display("FAIL sweep33_bl got=%0d exp=33", bl33); end
        total++; if (bl2 !== 2'd2) begin bad++; $display("FAIL sweep2_bl got=%0d exp=2", bl2); end
        for (int k = 1; k <= 33; k++) begin
            step(1'b1, 3'd5, 8'h00, 1'b0, 1'b0);
            exp33 = (v33 << k) | (v33 >> (33 - k));
            exp2  = (k % 2 == 0) ? 2'b10 : 2'b01;
            total++; if (q33 !== exp33) begin bad++; $display("FAIL sweep33_rol[%0d] got=%h exp=%h", k, q33, exp33); end
            total++; if (q2 !== exp2) begin bad++; $display("FAIL sweep2_rol[%0d] got=%b exp=%b", k, q2, exp2); end
            total++; if ($countones(q33) != 17) begin bad++; $display("FAIL sweep33_popcount[%0d] got=%0d exp=17", k, $countones(q33)); end
        end
        total++; if (q33 !== v33) begin bad++; $display("FAIL sweep33_restored got=%h exp=%h", q33, v33); end
        total++; if (bl33 !== 6'd33) begin bad++; $display("FAIL sweep33_bl_after got=%0d exp=33", bl33); end
    endtask

    initial begin
        test_reset();
        test_shr();
        test_shl();
        test_ror();
        test_en_hold();
        test_random();
        test_sweep();
        if (rsvd_seen > 0) $display("warning: reserved mode 111 applied %0d times", rsvd_seen);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
